// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default sizing,
// pointer type and Gray/binary conversion helpers.
package async_fifo_pkg;

    localparam int unsigned FIFO_ASIZE = 4;
    localparam int unsigned DEPTH      = 2 ** FIFO_ASIZE;
    localparam int unsigned PTR_W      = FIFO_ASIZE + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Gray encoding is width independent; callers truncate to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so the
    // result is the XOR of the masked Gray value shifted by 0..w-1.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
        logic [31:0] mask;
        logic [31:0] gm;
        logic [31:0] b;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        gm   = g & mask;
        b    = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < w) begin
                b = b ^ (gm >> k);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for synchronised pointers.
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Prefix XOR from the MSB down.
    always_comb begin
        bin = W'(gray2bin(32'(gray), W));
    end

endmodule

// File: rtl/rptr_empty_level.sv
// Read-domain pointer and status block: read pointer, empty/almost-empty
// flags, occupancy level and sticky underflow error.
module rptr_empty_level
    import async_fifo_pkg::*;
#(
    parameter int unsigned ASIZE         = 4,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic             rclr_err,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int unsigned    PW      = ASIZE + 1;
    localparam logic [ASIZE:0] THRESH  = PW'(AEMPTY_THRESH);
    localparam logic [ASIZE:0] LVL_MAX = {1'b1, {ASIZE{1'b0}}};

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] lvl_next;
    logic           pop;

    gray2bin_conv #(.W(PW)) u_wptr_conv (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // Next pointer and next occupancy; pops while empty are dropped.
    always_comb begin
        pop       = rinc & ~rempty;
        rbinnext  = rbin + PW'(pop);
        rgraynext = PW'(bin2gray(32'(rbinnext)));
        lvl_next  = wbin - rbinnext;
    end

    // RAM address comes straight from the binary pointer register.
    always_comb begin
        raddr = rbin[ASIZE-1:0];
    end

    // Pointer and status registers, all driven from next-state values.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            rempty     <= (rgraynext == rq2_wptr);
            raempty    <= (lvl_next <= THRESH);
            rlevel     <= lvl_next;
            runderflow <= (runderflow & ~rclr_err) | (rinc & rempty);
        end
    end

    a_empty_level : assert property (@(posedge rclk) disable iff (!rrst_n)
                                     rempty == (rlevel == '0));
    a_level_max   : assert property (@(posedge rclk) disable iff (!rrst_n)
                                     rlevel <= LVL_MAX);

endmodule

// File: tb/tb_rptr_empty_level.sv
// Self-checking bench for rptr_empty_level (ASIZE=4, AEMPTY_THRESH=2).
// Reference model tracks integer read/write counts.
module tb_rptr_empty_level;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic       rclr_err;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;

    int errors = 0;
    int checks = 0;

    // model state
    int   m_wr = 0;
    int   m_rd = 0;
    int   m_level = 0;
    logic m_empty = 1'b1;
    logic m_aempty = 1'b1;
    logic m_uf = 1'b0;

    rptr_empty_level #(.ASIZE(4), .AEMPTY_THRESH(2)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rclr_err   (rclr_err),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic set_wr(input int n);
        m_wr     = n;
        rq2_wptr = gray5(n);
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic pop;
        @(posedge rclk);
        if (!rrst_n) begin
            m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
        end else begin
            pop      = rinc && !m_empty;
            m_uf     = (m_uf && !rclr_err) || (rinc && m_empty);
            m_rd     = m_rd + (pop ? 1 : 0);
            m_level  = m_wr - m_rd;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 2);
        end
        #1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0; rinc = 1'b0; rclr_err = 1'b0;
        set_wr(5);
        tick();
        checks++; if (rempty !== 1'b1)  begin errors++; $display("FAIL reset_rempty got=%b exp=1", rempty); end
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty got=%b exp=1", raempty); end
        checks++; if (rlevel !== 5'd0)  begin errors++; $display("FAIL reset_rlevel got=%0d exp=0", rlevel); end
        checks++; if (rptr !== 5'd0)    begin errors++; $display("FAIL reset_rptr got=%b exp=00000", rptr); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", runderflow); end
        rrst_n = 1'b1;
        tick();
        checks++; if (rempty !== 1'b0)  begin errors++; $display("FAIL release_rempty got=%b exp=0", rempty); end
        checks++; if (rlevel !== 5'd5)  begin errors++; $display("FAIL release_rlevel got=%0d exp=5", rlevel); end
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL release_raempty got=%b exp=0", raempty); end
        checks++; if (rptr !== 5'd0)    begin errors++; $display("FAIL release_rptr got=%b exp=00000", rptr); end
    endtask

    task automatic test_drain();
        rrst_n = 1'b0; rinc = 1'b0; set_wr(3);
        tick();
        rrst_n = 1'b1;
        tick();
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (raddr !== 4'(i)) begin errors++; $display("FAIL drain_raddr[%0d] got=%0d exp=%0d", i, raddr, i); end
            checks++; if (rlevel !== 5'(3 - i)) begin errors++; $display("FAIL drain_rlevel[%0d] got=%0d exp=%0d", i, rlevel, 3 - i); end
            checks++; if (raempty !== ((3 - i) <= 2)) begin errors++; $display("FAIL drain_raempty[%0d] got=%b exp=%b", i, raempty, (3 - i) <= 2); end
            tick();
        end
        checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL drain_end_rlevel got=%0d exp=0", rlevel); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL drain_end_rempty got=%b exp=1", rempty); end
        checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL drain_end_rptr got=%b exp=00010", rptr); end
        tick();
        checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL drain_hold_raddr got=%0d exp=3", raddr); end
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL drain_uf got=%b exp=1", runderflow); end
    endtask

    task automatic test_underflow();
        rinc = 1'b1; rclr_err = 1'b0;
        tick();
        checks++; if (raddr !== 4'd3) begin errors++; $display("FAIL uf_raddr got=%0d exp=3", raddr); end
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", runderflow); end
        rinc = 1'b0;
        tick();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_hold got=%b exp=1", runderflow); end
        rclr_err = 1'b1;
        tick();
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", runderflow); end
        rinc = 1'b1;
        tick();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%b exp=1", runderflow); end
        rinc = 1'b0;
        tick();
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear2 got=%b exp=0", runderflow); end
        rclr_err = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_addr [3];
        logic [4:0] exp_ptr  [3];
        exp_addr = '{4'd15, 4'd0, 4'd1};
        exp_ptr  = '{5'b10000, 5'b00000, 5'b00001};
        rinc = 1'b1;
        for (int n = 0; n < 200 && m_rd < 30; n++) begin
            set_wr((m_rd + 16 < 30) ? m_rd + 16 : 30);
            tick();
        end
        checks++; if (m_rd != 30) begin errors++; $display("FAIL wrap_setup budget expired rd=%0d exp=30", m_rd); end
        rinc = 1'b0; rclr_err = 1'b1;
        set_wr(33);
        tick();
        rclr_err = 1'b0;
        checks++; if (rlevel !== 5'd3) begin errors++; $display("FAIL wrap_rlevel got=%0d exp=3", rlevel); end
        checks++; if (raddr !== 4'd14) begin errors++; $display("FAIL wrap_raddr0 got=%0d exp=14", raddr); end
        checks++; if (rptr !== 5'b10001) begin errors++; $display("FAIL wrap_rptr0 got=%b exp=10001", rptr); end
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (raddr !== exp_addr[i]) begin errors++; $display("FAIL wrap_raddr[%0d] got=%0d exp=%0d", i, raddr, exp_addr[i]); end
            checks++; if (rptr !== exp_ptr[i]) begin errors++; $display("FAIL wrap_rptr[%0d] got=%b exp=%b", i, rptr, exp_ptr[i]); end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrap_rempty got=%b exp=1", rempty); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL wrap_uf got=%b exp=0", runderflow); end
    endtask

    task automatic test_full();
        rrst_n = 1'b0; rinc = 1'b0; set_wr(16);
        tick();
        rrst_n = 1'b1;
        tick();
        checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL full_rlevel got=%0d exp=16", rlevel); end
        checks++; if (rempty !== 1'b0)  begin errors++; $display("FAIL full_rempty got=%b exp=0", rempty); end
        checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL full_raempty got=%b exp=0", raempty); end
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        checks++; if (rlevel !== 5'd15) begin errors++; $display("FAIL full_pop_rlevel got=%0d exp=15", rlevel); end
    endtask

    task automatic test_reset_mid();
        rrst_n = 1'b0; rinc = 1'b0; set_wr(10);
        tick();
        rrst_n = 1'b1;
        tick();
        rinc = 1'b1;
        for (int n = 0; n < 20 && m_rd < 7; n++) tick();
        checks++; if (raddr !== 4'd7) begin errors++; $display("FAIL mid_setup_raddr got=%0d exp=7", raddr); end
        rrst_n = 1'b0;
        tick();
        checks++; if (raddr !== 4'd0)  begin errors++; $display("FAIL mid_raddr got=%0d exp=0", raddr); end
        checks++; if (rptr !== 5'd0)   begin errors++; $display("FAIL mid_rptr got=%b exp=00000", rptr); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_rempty got=%b exp=1", rempty); end
        checks++; if (rlevel !== 5'd0) begin errors++; $display("FAIL mid_rlevel got=%0d exp=0", rlevel); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL mid_uf got=%b exp=0", runderflow); end
        rrst_n = 1'b1; rinc = 1'b0;
        tick();
        checks++; if (rlevel !== 5'd10) begin errors++; $display("FAIL mid_release_rlevel got=%0d exp=10", rlevel); end
        checks++; if (raddr !== 4'd0)   begin errors++; $display("FAIL mid_release_raddr got=%0d exp=0", raddr); end
    endtask

    task automatic test_random();
        int nw;
        for (int c = 0; c < 400; c++) begin
            rrst_n = ($urandom_range(0, 63) != 0);
            if (!rrst_n) begin
                set_wr($urandom_range(0, 16));
            end else begin
                nw = m_wr + $urandom_range(0, 3);
                if (nw > m_rd + 16) nw = m_rd + 16;
                set_wr(nw);
            end
            rinc     = $urandom_range(0, 1);
            rclr_err = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (raddr !== 4'(m_rd % 16)) begin errors++; $display("FAIL rnd_raddr c=%0d got=%0d exp=%0d", c, raddr, m_rd % 16); end
            checks++; if (rptr !== gray5(m_rd)) begin errors++; $display("FAIL rnd_rptr c=%0d got=%b exp=%b", c, rptr, gray5(m_rd)); end
            checks++; if (rlevel !== 5'(m_level)) begin errors++; $display("FAIL rnd_rlevel c=%0d got=%0d exp=%0d", c, rlevel, m_level); end
            checks++; if (rempty !== m_empty) begin errors++; $display("FAIL rnd_rempty c=%0d got=%b exp=%b", c, rempty, m_empty); end
            checks++; if (raempty !== m_aempty) begin errors++; $display("FAIL rnd_raempty c=%0d got=%b exp=%b", c, raempty, m_aempty); end
            checks++; if (runderflow !== m_uf) begin errors++; $display("FAIL rnd_uf c=%0d got=%b exp=%b", c, runderflow, m_uf); end
        end
        rrst_n = 1'b1; rinc = 1'b0; rclr_err = 1'b0;
    endtask

    initial begin
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rclr_err = 1'b0;
        rq2_wptr = '0;
        test_reset();
        test_drain();
        test_underflow();
        test_wrap();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
